mlp_arbiter: RTL and testbench
==============================

MLP_ARBITER -- requirements
Module: mlp_arbiter

Interface
REQ-001 Parameter NumReq, 4, number of requesters sharing one MLP engine; power of two, 2..8.
REQ-002 Parameter ResultBeats, 256, result_valid beats per inference.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid_i  input  NumReq  per-requester job request; held until done_o.
REQ-006 req_init_i  input  NumReq  per-requester op: 1 = weight init, 0 = inference start.
REQ-007 gnt_o  output  NumReq  one-hot grant, owner of the engine.
REQ-008 gnt_id_o  output  $clog2(NumReq)  index of current/last owner.
REQ-009 done_o  output  NumReq  one-cycle completion pulse to owner.
REQ-010 res_valid_o  output  NumReq  result_valid_i routed to owner only.
REQ-011 res_idx_o  output  8  result beat index 0..ResultBeats-1 during inference.
REQ-012 busy_o  output  1  high in any state other than Idle.
REQ-013 protocol_err_o  output  1  sticky protocol violation flag.
REQ-014 init_valid_o / start_valid_o  output  1 each  engine command strobes.
REQ-015 init_ready_i / start_ready_i  input  1 each  engine ready (high only when engine idle).
REQ-016 result_valid_i  input  1  engine result beat strobe.

Function
REQ-017 States SHALL be Idle, Issue, WaitInit, WaitResult, Done.
REQ-018 Idle: if any req_valid_i bit set, SHALL pick winner round-robin starting at rr_ptr, latch winner index and its req_init_i bit, go to Issue next cycle.
REQ-019 Idle with no request SHALL stay Idle; gnt_o = 0.
REQ-020 gnt_o SHALL be one-hot for the latched winner in Issue, WaitInit, WaitResult, Done; zero in Idle.
REQ-021 Issue: SHALL drive exactly one of init_valid_o (latched op = init) or start_valid_o (op = start); never both.
REQ-022 Issue: command accepted on cycle where strobe and matching ready_i are both high; then go to WaitInit (init) or WaitResult (start); otherwise hold strobe and stay.
REQ-023 Requester changes to req_valid_i / req_init_i after latching SHALL be ignored until Done.
REQ-024 WaitInit: SHALL go to Done on first cycle init_ready_i = 1 (engine back in idle).
REQ-025 WaitResult: each result_valid_i beat SHALL assert res_valid_o[winner] same cycle (combinational) with res_idx_o = beat count, then increment count.
REQ-026 WaitResult: beat with count = ResultBeats-1 SHALL move to Done next cycle; count clears to 0.
REQ-027 Done: done_o[winner] high exactly one cycle; rr_ptr <= (winner+1) mod NumReq; go to Idle.
REQ-028 Minimum turnaround: request in Idle -> strobe 1 cycle later; back-to-back jobs separated by one Idle cycle.
REQ-029 result_valid_i in any state other than WaitResult SHALL set protocol_err_o and be otherwise ignored; res_valid_o stays 0.
REQ-030 protocol_err_o clears only on reset.

Reset
REQ-031 rst_ni low SHALL immediately force state Idle, rr_ptr 0, beat count 0, latched winner 0, protocol_err_o 0.
REQ-032 During and after reset all outputs SHALL be 0 (gnt_id_o = 0) until first post-reset edge logic acts.
REQ-033 Reset mid-job SHALL abandon the job with no done_o pulse.

Verification
REQ-034 req_valid_i=0100, req_init_i=0100, readies high -> next cycle init_valid_o=1, gnt_o=0100; ready low 3 cycles then high -> done_o=0100 one cycle, rr_ptr=3.
REQ-035 Requester 1 start, engine emits 256 beats -> res_valid_o=0010 on each, res_idx_o 0..255, done_o=0010 one cycle after beat 255.
REQ-036 req_valid_i=1111 held, all starts, each job 256 beats -> grant order 0,1,2,3,0; never two gnt_o bits high.
REQ-037 start_ready_i low 10 cycles in Issue -> start_valid_o held high all 10 cycles, state unchanged, accept on cycle 11.
REQ-038 result_valid_i pulse while Idle -> protocol_err_o=1 and remains 1 through subsequent jobs; res_valid_o=0.
REQ-039 rst_ni low at beat 100 of a job -> outputs 0 asynchronously, no done_o; after release, new request from 0 granted normally.

Source files
------------

// File: rtl/mlp_arbiter.sv
// Round-robin arbiter that shares one MLP engine among NumReq requesters.
// It issues each winner's init/start command and routes result beats back to the owner.
module mlp_arbiter #(
    parameter int NumReq      = 4,
    parameter int ResultBeats = 256,
    localparam int IdW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_valid_i,
    input  logic [NumReq-1:0] req_init_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdW-1:0]    gnt_id_o,
    output logic [NumReq-1:0] done_o,
    output logic [NumReq-1:0] res_valid_o,
    output logic [7:0]        res_idx_o,
    output logic              busy_o,
    output logic              protocol_err_o,
    output logic              init_valid_o,
    output logic              start_valid_o,
    input  logic              init_ready_i,
    input  logic              start_ready_i,
    input  logic              result_valid_i
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitInit,
        StWaitResult,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   winner_q, winner_d;
    logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             op_init_q, op_init_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             perr_q, perr_d;

    logic             found;
    logic [IdW-1:0]   pick;
    logic [IdW-1:0]   idx;

    // NumReq is a power of two, so IdW-bit wraparound gives the modulo rotation.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = rr_ptr_q + IdW'(i);
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        rr_ptr_d      = rr_ptr_q;
        op_init_d     = op_init_q;
        cnt_d         = cnt_q;
        perr_d        = perr_q | (result_valid_i && (state_q != StWaitResult));
        gnt_o         = '0;
        done_o        = '0;
        res_valid_o   = '0;
        init_valid_o  = 1'b0;
        start_valid_o = 1'b0;

        if (state_q != StIdle) begin
            gnt_o[winner_q] = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (found) begin
                    winner_d  = pick;
                    op_init_d = req_init_i[pick];
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (op_init_q) begin
                    init_valid_o = 1'b1;
                    if (init_ready_i) state_d = StWaitInit;
                end else begin
                    start_valid_o = 1'b1;
                    if (start_ready_i) state_d = StWaitResult;
                end
            end
            StWaitInit: begin
                if (init_ready_i) state_d = StDone;
            end
            StWaitResult: begin
                if (result_valid_i) begin
                    res_valid_o[winner_q] = 1'b1;
                    if (cnt_q == 8'(ResultBeats - 1)) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StDone: begin
                done_o[winner_q] = 1'b1;
                rr_ptr_d         = winner_q + 1'b1;
                state_d          = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            winner_q  <= '0;
            rr_ptr_q  <= '0;
            op_init_q <= 1'b0;
            cnt_q     <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            rr_ptr_q  <= rr_ptr_d;
            op_init_q <= op_init_d;
            cnt_q     <= cnt_d;
            perr_q    <= perr_d;
        end
    end

    assign gnt_id_o       = winner_q;
    assign res_idx_o      = cnt_q;
    assign busy_o         = (state_q != StIdle);
    assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_mlp_arbiter.sv
// Directed bench for mlp_arbiter: grant order, command handshakes, result routing,
// protocol error flag and mid-job reset, checked against a beat/grant scoreboard.
module tb_mlp_arbiter;

    localparam int N  = 4;
    localparam int RB = 256;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [N-1:0]  req_valid_i, req_init_i;
    logic [N-1:0]  gnt_o, done_o, res_valid_o;
    logic [1:0]    gnt_id_o;
    logic [7:0]    res_idx_o;
    logic          busy_o, protocol_err_o, init_valid_o, start_valid_o;
    logic          init_ready_i, start_ready_i, result_valid_i;

    mlp_arbiter #(.NumReq(N), .ResultBeats(RB)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_init_i(req_init_i),
        .gnt_o(gnt_o), .gnt_id_o(gnt_id_o), .done_o(done_o),
        .res_valid_o(res_valid_o), .res_idx_o(res_idx_o),
        .busy_o(busy_o), .protocol_err_o(protocol_err_o),
        .init_valid_o(init_valid_o), .start_valid_o(start_valid_o),
        .init_ready_i(init_ready_i), .start_ready_i(start_ready_i),
        .result_valid_i(result_valid_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N-1:0] vld;
        logic [7:0]   idx;
    } beat_t;

    beat_t bq[$];
    int    gq[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cur_w = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] oh(input int w);
        return (w < 0) ? 32'd0 : (32'd1 << w);
    endfunction

    // One edge from Idle with requests pending must land in Issue with the expected owner.
    task automatic expect_issue(input bit init);
        int w;
        tick;
        #1;
        w = (gq.size() > 0) ? gq.pop_front() : -1;
        chk("issue_cmd", {30'd0, init_valid_o, start_valid_o}, init ? 32'd2 : 32'd1);
        chk("issue_gnt", {28'd0, gnt_o}, oh(w));
        chk("issue_id", {30'd0, gnt_id_o}, 32'(w));
        chk("issue_busy", {31'd0, busy_o}, 32'd1);
        cur_w = w;
    endtask

    // Called while in Issue with start_ready_i high: accept, stream RB beats, Done, Idle.
    task automatic run_start(input int w, input bit drop_req);
        beat_t e;
        tick;
        start_ready_i = 1'b0;
        init_ready_i  = 1'b0;
        #1;
        chk("acc_strobe_low", {31'd0, start_valid_o}, 32'd0);
        chk("wr_gnt", {28'd0, gnt_o}, oh(w));
        for (int b = 0; b < RB; b++) begin
            result_valid_i = 1'b1;
            bq.push_back('{vld: N'(oh(w)), idx: 8'(b)});
            #1;
            e = bq.pop_front();
            chk("beat_vld", {28'd0, res_valid_o}, {28'd0, e.vld});
            chk("beat_idx", {24'd0, res_idx_o}, {24'd0, e.idx});
            tick;
        end
        result_valid_i = 1'b0;
        #1;
        chk("done_pulse", {28'd0, done_o}, oh(w));
        chk("done_gnt", {28'd0, gnt_o}, oh(w));
        if (drop_req) req_valid_i = '0;
        start_ready_i = 1'b1;
        init_ready_i  = 1'b1;
        tick;
        #1;
        chk("idle_done", {28'd0, done_o}, 32'd0);
        chk("idle_gnt", {28'd0, gnt_o}, 32'd0);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        beat_t e;
        rst_ni         = 1'b0;
        req_valid_i    = '0;
        req_init_i     = '0;
        init_ready_i   = 1'b1;
        start_ready_i  = 1'b1;
        result_valid_i = 1'b0;
        #3;
        chk("rst_gnt", {28'd0, gnt_o}, 32'd0);
        chk("rst_id", {30'd0, gnt_id_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_perr", {31'd0, protocol_err_o}, 32'd0);
        chk("rst_cmd", {30'd0, init_valid_o, start_valid_o}, 32'd0);
        chk("rst_res", {20'd0, res_valid_o, res_idx_o}, 32'd0);
        tick;
        tick;
        rst_ni = 1'b1;
        tick;

        // Init job from requester 2 with the engine busy for three cycles.
        req_valid_i = 4'b0100;
        req_init_i  = 4'b0100;
        gq.push_back(2);
        expect_issue(1'b1);
        tick;
        init_ready_i  = 1'b0;
        start_ready_i = 1'b0;
        #1;
        chk("wi_strobe", {31'd0, init_valid_o}, 32'd0);
        chk("wi_gnt", {28'd0, gnt_o}, 32'b0100);
        for (int k = 0; k < 3; k++) begin
            tick;
            #1;
            chk("wi_wait_done", {28'd0, done_o}, 32'd0);
        end
        init_ready_i  = 1'b1;
        start_ready_i = 1'b1;
        tick;
        #1;
        chk("init_done", {28'd0, done_o}, 32'b0100);
        req_valid_i = '0;
        req_init_i  = '0;
        tick;
        #1;
        chk("init_idle_done", {28'd0, done_o}, 32'd0);

        // Pointer now at 3: requesters 0,1,3 pending must pick 3.
        req_valid_i = 4'b1011;
        gq.push_back(3);
        expect_issue(1'b0);
        run_start(cur_w, 1'b1);

        // All four held: grants rotate 0,1,2,3,0.
        req_valid_i = 4'b1111;
        gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
        for (int j = 0; j < 5; j++) begin
            expect_issue(1'b0);
            run_start(cur_w, j == 4);
        end

        // Requester 1 inference.
        req_valid_i = 4'b0010;
        gq.push_back(1);
        expect_issue(1'b0);
        run_start(cur_w, 1'b1);

        // Stray result beat while Idle.
        chk("perr_before", {31'd0, protocol_err_o}, 32'd0);
        result_valid_i = 1'b1;
        #1;
        chk("stray_resvld", {28'd0, res_valid_o}, 32'd0);
        tick;
        result_valid_i = 1'b0;
        #1;
        chk("perr_set", {31'd0, protocol_err_o}, 32'd1);

        // Start held off for ten Issue cycles, accepted on the eleventh.
        start_ready_i = 1'b0;
        req_valid_i   = 4'b0001;
        gq.push_back(0);
        expect_issue(1'b0);
        for (int k = 1; k < 10; k++) begin
            tick;
            #1;
            chk("stall_strobe", {31'd0, start_valid_o}, 32'd1);
            chk("stall_gnt", {28'd0, gnt_o}, 32'b0001);
        end
        start_ready_i = 1'b1;
        run_start(cur_w, 1'b1);
        chk("perr_sticky", {31'd0, protocol_err_o}, 32'd1);

        // Reset at beat 100 of a job from requester 2.
        req_valid_i = 4'b0100;
        gq.push_back(2);
        expect_issue(1'b0);
        tick;
        start_ready_i = 1'b0;
        init_ready_i  = 1'b0;
        for (int b = 0; b < 100; b++) begin
            result_valid_i = 1'b1;
            bq.push_back('{vld: 4'b0100, idx: 8'(b)});
            #1;
            e = bq.pop_front();
            chk("pre_rst_idx", {24'd0, res_idx_o}, {24'd0, e.idx});
            tick;
        end
        result_valid_i = 1'b1;
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_gnt", {28'd0, gnt_o}, 32'd0);
        chk("arst_id", {30'd0, gnt_id_o}, 32'd0);
        chk("arst_res", {20'd0, res_valid_o, res_idx_o}, 32'd0);
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_perr", {31'd0, protocol_err_o}, 32'd0);
        result_valid_i = 1'b0;
        req_valid_i    = '0;
        start_ready_i  = 1'b1;
        init_ready_i   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick;
            #1;
            chk("arst_no_done", {28'd0, done_o}, 32'd0);
        end
        rst_ni = 1'b1;
        tick;

        // Pointer back at 0 after reset: 0 beats 3.
        req_valid_i = 4'b1001;
        gq.push_back(0);
        expect_issue(1'b0);
        run_start(cur_w, 1'b1);
        chk("post_rst_perr", {31'd0, protocol_err_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
